// File: rtl/pipe_pkg.sv
// Shared types, defaults and reset-value helper for the decode-stage register file.
package pipe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Register i resets to its own index, truncated to a w-bit register.
  function automatic logic [31:0] reset_value(input int unsigned i, input int unsigned w);
    if (w >= 32) return i;
    return i & ((32'h1 << w) - 32'h1);
  endfunction

endpackage

// File: rtl/pipe_regfile_rdport.sv
// One asynchronous read port: range check, write-back bypass and busy qualification.
// PIPE_REGFILE_ZERO_REG_EN makes address 0 read as a constant, never-busy zero.
module pipe_regfile_rdport
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 8
) (
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy,
  input  logic                             wr_ok,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_busy
);

  logic              hit;
  logic              byp;
  logic              sb;
  logic [DATA_W-1:0] stor;

  always_comb begin
    hit  = 1'b0;
    sb   = 1'b0;
    stor = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        hit  = 1'b1;
        stor = regs[i];
        sb   = busy[i];
      end
    end
`ifdef PIPE_REGFILE_ZERO_REG_EN
    if (rd_addr == '0) hit = 1'b0;
`endif
    // wr_ok already excludes out-of-range and hardwired targets, so byp implies hit.
    byp     = wr_ok && (wr_addr == rd_addr);
    rd_data = !hit ? '0 : (byp ? wr_data : stor);
    rd_busy = hit & sb & ~byp;
  end

endmodule

// File: rtl/pipe_regfile_sb.sv
// Decode-stage register file with NUM_RD bypassed read ports and a RAW busy scoreboard.
// Define PIPE_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module pipe_regfile_sb
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       stall,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_dst,
  output logic [NUM_REGS-1:0]        busy_vec
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy_q;
  logic                            wr_ok;
  logic                            iss_ok;

  // Qualified strobes: in range and not targeting a hardwired register.
  always_comb begin
    wr_ok  = 1'b0;
    iss_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_ok  = wr_en;
      if (iss_dst == ADDR_W'(i)) iss_ok = iss_en;
    end
`ifdef PIPE_REGFILE_ZERO_REG_EN
    if (wr_addr == '0) wr_ok  = 1'b0;
    if (iss_dst == '0) iss_ok = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_W'(reset_value($unsigned(i), $unsigned(DATA_W)));
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
        // Issue beats write-back: the newer producer owns the register.
        if (iss_ok && iss_dst == ADDR_W'(i))
          busy_q[i] <= 1'b1;
        else if (wr_ok && wr_addr == ADDR_W'(i))
          busy_q[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    pipe_regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
    ) u_rdport (
      .rd_addr (rd_addr[k*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy_q),
      .wr_ok   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[k])
    );
  end

  assign stall    = |(rd_en & rd_busy);
  assign busy_vec = busy_q;

endmodule
